// File: rtl/riscv_prefetch_buffer.sv
// fifo: generic synchronous FIFO with flush; head is presented straight from storage.
// Latency: a push is visible at the head one cycle later; pop takes effect at the next edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic                     head_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
endmodule

// riscv_prefetch_buffer: owns the fetch PC, issues in-order word reads and buffers returned instructions.
// Latency: response in cycle N+L is presented at the head in N+L+1; redirect empties the head next cycle.
// Backpressure: requests stop when buffered + in-flight reaches DEPTH; responses are never back-pressured.
module riscv_prefetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    output logic            o_instr_valid_f,
    output logic [XLEN-1:0] o_instr_f,
    output logic [XLEN-1:0] o_pc_f,
    output logic [XLEN-1:0] o_pc_plus_4_f,
    input  logic            i_stall_f,
    input  logic            i_redirect_e,
    input  logic [XLEN-1:0] i_redirect_pc_e
);
    localparam int              CW  = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redirect_pc;
    logic            req_acc;
    logic            push;
    logic            pop;
    logic            head_vld;
    entry_t          head;
    entry_t          push_entry;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^i_redirect_pc_e[1:0];
    assign redirect_pc    = {i_redirect_pc_e[XLEN-1:2], 2'b00};

    assign credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};
    assign o_imem_req_valid = !i_rst && !i_redirect_e && (credit_used < (CW+1)'(DEPTH));
    assign o_imem_req_addr  = req_pc;
    assign req_acc          = o_imem_req_valid && i_imem_req_ready;

    assign push       = i_imem_rsp_valid && (discard == '0) && !i_redirect_e;
    assign pop        = head_vld && !i_stall_f && !i_redirect_e;
    assign push_entry = '{instr: i_imem_rsp_data, pc: rsp_pc};

    fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .flush    (i_redirect_e),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head),
        .count    (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_acc) - CW'(i_imem_rsp_valid);
            if (i_redirect_e) begin
                req_pc  <= redirect_pc;
                rsp_pc  <= redirect_pc;
                // Every request still in flight belongs to the abandoned stream,
                // including those already marked for discard.
                discard <= outstanding - CW'(i_imem_rsp_valid);
            end else begin
                if (req_acc) req_pc <= req_pc + XLEN'(4);
                if (i_imem_rsp_valid) begin
                    if (discard != '0) discard <= discard - CW'(1);
                    else               rsp_pc  <= rsp_pc + XLEN'(4);
                end
            end
        end
    end

    assign o_instr_valid_f = head_vld;
    assign o_instr_f       = head_vld ? head.instr : NOP;
    assign o_pc_f          = head_vld ? head.pc : '0;
    assign o_pc_plus_4_f   = head_vld ? head.pc + XLEN'(4) : '0;
endmodule
